div_ctrl: RTL

Run-time controller for the integer clock divider. It holds the active divide ratio and duty, and accepts new ratios over a valid/ready handshake. New ratios are applied only at period boundaries, so `div_out` never has a runt pulse. Start and stop are graceful: `en` is sampled and the last period always completes. The block sits between the control registers and any logic that consumes a divided enable/clock waveform.

---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/div_ctrl_if.sv | 20 ++
 rtl/div_ctrl_core.sv | 42 ++++
 rtl/div_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl shared types and reset defaults.
// State encoding for the controller FSM plus default ratio/duty.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DIV  = 6;
    localparam int DEF_HIGH = 3;

endpackage

// File: rtl/div_ctrl_if.sv
// Config handshake bundle for div_ctrl.
// master offers a ratio/duty pair, slave answers with ready.
interface div_ctrl_if #(
    parameter int CW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_div;
    logic [CW-1:0] cfg_high;

    modport master (
        output cfg_valid, cfg_div, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/div_ctrl_core.sv
// Period counter, wrap detect and registered div_out.
// Next-cycle run/high come from the controller so div_out tracks cnt.
module div_ctrl_core
    import div_ctrl_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  state_t        state,
    input  logic          run_nxt,
    input  logic [CW-1:0] act_div,
    input  logic [CW-1:0] act_high_nxt,
    output logic          wrap,
    output logic          div_out
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign wrap = (state != IDLE) && (cnt == act_div - CW'(1));

    // Count while running; restart at 0 on start, wrap or stop.
    always_comb begin
        cnt_nxt = cnt + CW'(1);
        if (!run_nxt || state == IDLE || wrap) begin
            cnt_nxt = '0;
        end
    end

    // Counter and glitch-free output flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_out <= run_nxt && (cnt_nxt < act_high_nxt);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Run-time divider controller: shadow config, boundary apply, graceful stop.
// Define DIV_CTRL_ERR_EN to reject illegal configs and expose sticky err.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CW         = 8,
    parameter int RESET_DIV  = DEF_DIV,
    parameter int RESET_HIGH = DEF_HIGH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    div_ctrl_if.slave  cfg,
    output logic       div_out,
    output logic       period_tick,
    output logic       busy,
    output logic       pending
`ifdef DIV_CTRL_ERR_EN
    ,
    output logic       err
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] act_div;
    logic [CW-1:0] act_high;
    logic [CW-1:0] pend_div;
    logic [CW-1:0] pend_high;
    logic [CW-1:0] new_div;
    logic [CW-1:0] new_high;
    logic [CW-1:0] act_high_nxt;
    logic          wrap;
    logic          apply;
    logic          accept;
    logic          legal;
    logic          run_nxt;

    assign cfg.cfg_ready = !pending;
    assign accept        = cfg.cfg_valid && !pending;
    assign busy          = (state != IDLE);
    assign period_tick   = wrap;
    assign run_nxt       = (state_nxt != IDLE);
    assign act_high_nxt  = apply ? pend_high : act_high;

    // Next state and apply points: start, or any period wrap.
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    apply     = pending;
                end
            end
            RUN: begin
                if (wrap) begin
                    apply = pending;
                    if (!en) state_nxt = IDLE;
                end else if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                apply = pending && wrap;
                if (en) state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Legalise an offered config before it reaches the shadow.
    always_comb begin
`ifdef DIV_CTRL_ERR_EN
        new_div  = cfg.cfg_div;
        new_high = cfg.cfg_high;
        legal    = (cfg.cfg_div >= CW'(2))
                && (cfg.cfg_high >= CW'(1))
                && (cfg.cfg_high <= cfg.cfg_div - CW'(1));
`else
        legal    = 1'b1;
        new_div  = (cfg.cfg_div < CW'(2)) ? CW'(2) : cfg.cfg_div;
        new_high = cfg.cfg_high;
        if (cfg.cfg_high == '0) begin
            new_high = CW'(1);
        end else if (cfg.cfg_high > new_div - CW'(1)) begin
            new_high = new_div - CW'(1);
        end
`endif
    end

    // FSM state, active/shadow config and pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            act_div   <= CW'(RESET_DIV);
            act_high  <= CW'(RESET_HIGH);
            pend_div  <= '0;
            pend_high <= '0;
            pending   <= 1'b0;
`ifdef DIV_CTRL_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (apply) begin
                act_div  <= pend_div;
                act_high <= pend_high;
                pending  <= 1'b0;
            end else if (accept && legal) begin
                pend_div  <= new_div;
                pend_high <= new_high;
                pending   <= 1'b1;
            end
`ifdef DIV_CTRL_ERR_EN
            if (accept && !legal) err <= 1'b1;
`endif
        end
    end

    div_ctrl_core #(.CW(CW)) u_core (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .run_nxt      (run_nxt),
        .act_div      (act_div),
        .act_high_nxt (act_high_nxt),
        .wrap         (wrap),
        .div_out      (div_out)
    );

endmodule
